dht11_sensor_emulator: RTL and testbench

Responder end of the DHT11 single-wire protocol. The block behaves like a DHT11 sensor on the shared open-drain bus. It detects the host start pulse, answers with the 83us/87us acknowledge, then shifts out a 40-bit frame: 32 payload bits plus an 8-bit checksum. It serves as a loopback/bench partner for the DHT11 host reader and as a stand-in sensor on boards without one.

---
 rtl/dht11_sensor_emulator.sv | 209 ++++++++++++++++++++
 tb/tb_dht11_sensor_emulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emulator.sv
// ---------------------------------------------------------------------------
// dht11_sensor_emulator
//
// Sensor (responder) side of the DHT11 single-wire protocol. Waits for a host
// start pulse on the open-drain bus, answers with the acknowledge low/high
// pair, then shifts out 40 bits: the 32-bit payload followed by an 8-bit
// checksum (sum of the four payload bytes, modulo 256). Once a frame has
// started, bus activity is ignored until the frame is complete.
//
// Ports:
//   sys_clk      system clock
//   rst_n        asynchronous active-low reset
//   dht11        open-drain bus; only ever driven 0 or released to Z
//   data_in      payload {hum_int, hum_dec, temp_int, temp_dec}, MSB first
//   busy         high from accepted start until the end of the frame
//   frame_done   one-cycle pulse after the final low is released
//   corrupt_csum (only with DHT11_EMU_CSUM_ERR_EN) send the inverted checksum
//
// Build option:
//   DHT11_EMU_CSUM_ERR_EN  adds the corrupt_csum input for checksum-error
//                          injection. Without it the checksum is always correct.
// ---------------------------------------------------------------------------
module dht11_sensor_emulator #(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned MIN_START_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 13,
  parameter int unsigned RESP_LOW_US   = 83,
  parameter int unsigned RESP_HIGH_US  = 87,
  parameter int unsigned BIT_LOW_US    = 54,
  parameter int unsigned BIT0_HIGH_US  = 24,
  parameter int unsigned BIT1_HIGH_US  = 71
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  inout  wire         dht11,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        frame_done
`ifdef DHT11_EMU_CSUM_ERR_EN
  ,
  input  logic        corrupt_csum
`endif
);

  // Cycles per microsecond tick; clamped so very slow clocks still build.
  localparam int unsigned TICK_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ?
                                     (CLK_FREQ_HZ / 1_000_000) : 1;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Microsecond counter saturates, so an arbitrarily long host low still
  // compares correctly against MIN_START_US.
  localparam int unsigned US_W     = 20;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t              state_q, state_d;
  logic                bus_s1_q, bus_s2_q, bus_prev_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [US_W-1:0]     us_q, us_d;
  logic [39:0]         shift_q, shift_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                drive_low_q, drive_low_d;
  logic                tick;
  logic                bus_fall, bus_rise;
  logic [7:0]          csum_tx;

  function automatic logic [7:0] checksum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

  // True in the last cycle of a state lasting dur_us whole ticks, so the
  // next state begins exactly dur_us * TICK_DIV cycles after entry.
  function automatic logic elapsed(input logic [US_W-1:0] us,
                                   input logic            tk,
                                   input int unsigned     dur_us);
    return tk && (us == US_W'(dur_us - 1));
  endfunction

  assign tick     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign bus_fall = bus_prev_q & ~bus_s2_q;
  assign bus_rise = ~bus_prev_q & bus_s2_q;

`ifdef DHT11_EMU_CSUM_ERR_EN
  assign csum_tx = corrupt_csum ? ~checksum(data_in) : checksum(data_in);
`else
  assign csum_tx = checksum(data_in);
`endif

  // Next-state and frame control.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_fall) state_d = START_LOW;
      end
      START_LOW: begin
        if (bus_rise) begin
          if (us_q >= US_W'(MIN_START_US)) begin
            state_d   = WAIT_RESP;
            busy_d    = 1'b1;
            // Payload and checksum are frozen here for the whole frame.
            shift_d   = {data_in, csum_tx};
            bit_cnt_d = 6'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RESP: begin
        if (elapsed(us_q, tick, RESP_DELAY_US)) state_d = RESP_LOW;
      end
      RESP_LOW: begin
        if (elapsed(us_q, tick, RESP_LOW_US)) state_d = RESP_HIGH;
      end
      RESP_HIGH: begin
        if (elapsed(us_q, tick, RESP_HIGH_US)) state_d = BIT_LOW;
      end
      BIT_LOW: begin
        if (elapsed(us_q, tick, BIT_LOW_US)) state_d = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (elapsed(us_q, tick, shift_q[39] ? BIT1_HIGH_US : BIT0_HIGH_US)) begin
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        if (elapsed(us_q, tick, BIT_LOW_US)) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timebase restarts on every state entry; held at zero while idle.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    us_d       = us_q;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      tick_cnt_d = '0;
      us_d       = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      if (us_q != {US_W{1'b1}}) us_d = us_q + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Drive is registered from the next state so the bus edge is glitch-free.
  always_comb begin
    drive_low_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) ||
                  (state_d == END_LOW);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bus_s1_q     <= 1'b1;
      bus_s2_q     <= 1'b1;
      bus_prev_q   <= 1'b1;
      tick_cnt_q   <= '0;
      us_q         <= '0;
      bit_cnt_q    <= 6'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drive_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_s1_q     <= dht11;
      bus_s2_q     <= bus_s1_q;
      bus_prev_q   <= bus_s2_q;
      tick_cnt_q   <= tick_cnt_d;
      us_q         <= us_d;
      bit_cnt_q    <= bit_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drive_low_q  <= drive_low_d;
    end
  end

  // Frame shift register: pure data, reloaded at every accepted start.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
  end

  assign dht11      = drive_low_q ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
`timescale 1ns/1ps
module tb_dht11_sensor_emulator;

  // 2 cycles per microsecond keeps full frames short; start threshold scaled down.
  localparam int DIV       = 2;
  localparam int MIN_START = 200;
  localparam int LIMIT     = 400 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_low;
  logic [31:0] data_in;
  logic        busy;
  logic        frame_done;
  wire         dht11;
`ifdef DHT11_EMU_CSUM_ERR_EN
  logic        corrupt_csum;
`endif

  pullup (dht11);
  assign dht11 = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emulator #(
    .CLK_FREQ_HZ (2_000_000),
    .MIN_START_US(MIN_START)
  ) dut (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .dht11     (dht11),
    .data_in   (data_in),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef DHT11_EMU_CSUM_ERR_EN
    ,
    .corrupt_csum(corrupt_csum)
`endif
  );

  always #5 clk = ~clk;

  int fd_cnt = 0;
  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  int checks = 0;
  int errors = 0;

  // Results of the most recent received frame (durations in clock cycles).
  int gap_c, rlo_c, rhi_c, end_c;
  int lo_min, lo_max, h1_min, h1_max, h0_min, h0_max;
  logic busy_seen;
  bit   to_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
    checks++;
    assert (val >= lo && val <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic host_start(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Counts consecutive negedge samples at level lvl; bounded by LIMIT.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (dht11 === lvl && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    if (n >= LIMIT) to_err = 1'b1;
  endtask

  task automatic rx_frame(output logic [39:0] bits);
    int n;
    bits   = '0;
    to_err = 1'b0;
    lo_min = 1 << 30; lo_max = 0;
    h1_min = 1 << 30; h1_max = 0;
    h0_min = 1 << 30; h0_max = 0;
    @(negedge clk);
    measure(1'b1, n); gap_c = n; busy_seen = busy;
    measure(1'b0, n); rlo_c = n;
    measure(1'b1, n); rhi_c = n;
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, n);
      if (n < lo_min) lo_min = n;
      if (n > lo_max) lo_max = n;
      measure(1'b1, n);
      // Midpoint of 24us and 71us separates 0 from 1.
      if (n > ((24 + 71) * DIV) / 2) begin
        bits = {bits[38:0], 1'b1};
        if (n < h1_min) h1_min = n;
        if (n > h1_max) h1_max = n;
      end else begin
        bits = {bits[38:0], 1'b0};
        if (n < h0_min) h0_min = n;
        if (n > h0_max) h0_max = n;
      end
    end
    measure(1'b0, n); end_c = n;
  endtask

  logic [39:0] bits;
  int   fd0, cnt, guard;
  logic prev, saw_low, saw_busy;

  initial begin
    rst_n    = 1'b0;
    host_low = 1'b0;
    data_in  = '0;
`ifdef DHT11_EMU_CSUM_ERR_EN
    corrupt_csum = 1'b0;
`endif
    repeat (5) @(negedge clk);
    chk("reset_bus", {63'd0, dht11}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame
    data_in = 32'h3C00_1900;
    fd0 = fd_cnt;
    host_start(250);
    rx_frame(bits);
    repeat (4) @(negedge clk);
    chk("basic_timeout", {63'd0, to_err}, 64'd0);
    chk("basic_busy", {63'd0, busy_seen}, 64'd1);
    // Response delay plus up to a few cycles of synchronizer latency.
    chk_rng("basic_gap", gap_c, 13 * DIV, 13 * DIV + 6);
    chk_rng("basic_resp_low", rlo_c, 83 * DIV - DIV, 83 * DIV + DIV);
    chk_rng("basic_resp_high", rhi_c, 87 * DIV - DIV, 87 * DIV + DIV);
    chk("basic_bits", {24'd0, bits}, {24'd0, 32'h3C00_1900, 8'h55});
    chk_rng("basic_end_low", end_c, 54 * DIV - DIV, 54 * DIV + DIV);
    chk("basic_frame_done", fd_cnt - fd0, 64'd1);
    chk("basic_busy_after", {63'd0, busy}, 64'd0);

    // Short start is ignored
    fd0 = fd_cnt;
    host_start(100);
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    repeat (300 * DIV) begin
      @(negedge clk);
      if (dht11 !== 1'b1) saw_low = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    chk("short_bus_idle", {63'd0, saw_low}, 64'd0);
    chk("short_busy", {63'd0, saw_busy}, 64'd0);
    chk("short_no_frame", fd_cnt - fd0, 64'd0);

    // All-ones payload: bit timing
    data_in = 32'hFFFF_FFFF;
    host_start(250);
    rx_frame(bits);
    repeat (4) @(negedge clk);
    chk("ones_timeout", {63'd0, to_err}, 64'd0);
    chk("ones_bits", {24'd0, bits}, {24'd0, 32'hFFFF_FFFF, 8'hFC});
    chk_rng("ones_h1_min", h1_min, 71 * DIV - DIV, 71 * DIV + DIV);
    chk_rng("ones_h1_max", h1_max, 71 * DIV - DIV, 71 * DIV + DIV);
    chk_rng("ones_h0_min", h0_min, 24 * DIV - DIV, 24 * DIV + DIV);
    chk_rng("ones_h0_max", h0_max, 24 * DIV - DIV, 24 * DIV + DIV);
    chk_rng("ones_lo_min", lo_min, 54 * DIV - DIV, 54 * DIV + DIV);
    chk_rng("ones_lo_max", lo_max, 54 * DIV - DIV, 54 * DIV + DIV);

    // Payload change during bit 5 must not affect the frame
    data_in = 32'hDEAD_BEEF;
    fd0 = fd_cnt;
    host_start(250);
    fork
      rx_frame(bits);
      begin
        repeat (1600) @(negedge clk);
        data_in = 32'h1234_5678;
      end
    join
    repeat (4) @(negedge clk);
    chk("latch_bits", {24'd0, bits}, {24'd0, 32'hDEAD_BEEF, 8'h38});
    chk("latch_frame_done", fd_cnt - fd0, 64'd1);

    // Reset while driving the bit-20 low
    data_in = 32'h3C00_1900;
    fd0 = fd_cnt;
    host_start(250);
    cnt   = 0;
    guard = 0;
    prev  = 1'b1;
    while (cnt < 22 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (prev === 1'b1 && dht11 === 1'b0) cnt++;
      prev = dht11;
    end
    chk("midrst_reach_bit20", cnt, 64'd22);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_bus_released", {63'd0, dht11}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_frame_done", fd_cnt - fd0, 64'd0);
    host_start(250);
    rx_frame(bits);
    repeat (4) @(negedge clk);
    chk("midrst_next_bits", {24'd0, bits}, {24'd0, 32'h3C00_1900, 8'h55});
    chk("midrst_next_frame_done", fd_cnt - fd0, 64'd1);

`ifdef DHT11_EMU_CSUM_ERR_EN
    // Corrupted checksum injection
    corrupt_csum = 1'b1;
    data_in = 32'h3C00_1900;
    host_start(250);
    rx_frame(bits);
    repeat (4) @(negedge clk);
    chk("corrupt_bits", {24'd0, bits}, {24'd0, 32'h3C00_1900, 8'hAA});
    corrupt_csum = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
